divider: RTL and testbench

Iterative 32-bit integer divider; the division counterpart to the single-cycle-issue Booth/CSA multiplier in the ALU execute stage. It accepts a start pulse with two operands, runs a radix-2 restoring division over 32 iterations, and returns quotient and remainder with a one-cycle done pulse. It supports signed and unsigned division and defines divide-by-zero and overflow results so the execute stage never stalls on a special case.

---
 rtl/divider_if.sv | 35 +++
 rtl/divider.sv | 153 +++++++++++++++
 tb/tb_divider.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Handshake and operand/result bundle between the execute stage and the
// iterative divider. The execute stage drives the request side (master),
// the divider drives the result side (slave).
interface divider_if;
  logic        div_begin;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_busy;
  logic        div_end;

  modport master (
    output div_begin,
    output div_signed,
    output div_op1,
    output div_op2,
    input  div_quot,
    input  div_rem,
    input  div_busy,
    input  div_end
  );

  modport slave (
    input  div_begin,
    input  div_signed,
    input  div_op1,
    input  div_op2,
    output div_quot,
    output div_rem,
    output div_busy,
    output div_end
  );
endinterface

// File: rtl/divider.sv
// Iterative 32-bit radix-2 restoring divider, signed or unsigned.
// Works on operand magnitudes for 32 cycles and applies sign correction
// on the final iteration. Divide-by-zero returns all-ones quotient and the
// untouched dividend as remainder. Results are held until the next
// completion, and a new divide may be accepted in the DONE cycle.
module divider (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q,     state_d;
  logic [4:0]  cnt_q,       cnt_d;
  logic [31:0] acc_rem_q,   acc_rem_d;
  logic [31:0] acc_quot_q,  acc_quot_d;
  logic [31:0] dvsr_q,      dvsr_d;
  logic [31:0] dvnd_q,      dvnd_d;
  logic        neg_quot_q,  neg_quot_d;
  logic        neg_rem_q,   neg_rem_d;
  logic        div_zero_q,  div_zero_d;
  logic [31:0] div_quot_q,  div_quot_d;
  logic [31:0] div_rem_q,   div_rem_d;
  logic        div_busy_q,  div_busy_d;
  logic        div_end_q,   div_end_d;

  logic        start;
  logic [31:0] op1_mag;
  logic [31:0] op2_mag;
  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic [31:0] quot_step;
  logic [31:0] rem_step;
  logic [31:0] fin_quot;
  logic [31:0] fin_rem;

  // One restoring step plus the operand magnitudes and final sign fix-up.
  // The 33-bit trial keeps a 0x80000000 divisor magnitude exact.
  always_comb begin
    start     = bus.div_begin && (state_q != RUN);
    op1_mag   = (bus.div_signed && bus.div_op1[31]) ? (32'd0 - bus.div_op1) : bus.div_op1;
    op2_mag   = (bus.div_signed && bus.div_op2[31]) ? (32'd0 - bus.div_op2) : bus.div_op2;
    rem_shift = {acc_rem_q, acc_quot_q[31]};
    trial     = rem_shift - {1'b0, dvsr_q};
    quot_step = {acc_quot_q[30:0], ~trial[32]};
    rem_step  = trial[32] ? rem_shift[31:0] : trial[31:0];
    if (div_zero_q) begin
      fin_quot = 32'hFFFF_FFFF;
      fin_rem  = dvnd_q;
    end else begin
      fin_quot = neg_quot_q ? (32'd0 - quot_step) : quot_step;
      fin_rem  = neg_rem_q  ? (32'd0 - rem_step)  : rem_step;
    end
  end

  // Next-state logic for the controller, datapath and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_rem_d  = acc_rem_q;
    acc_quot_d = acc_quot_q;
    dvsr_d     = dvsr_q;
    dvnd_d     = dvnd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    div_quot_d = div_quot_q;
    div_rem_d  = div_rem_q;
    div_busy_d = div_busy_q;
    div_end_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          cnt_d      = 5'd0;
          acc_rem_d  = 32'd0;
          acc_quot_d = op1_mag;
          dvsr_d     = op2_mag;
          dvnd_d     = bus.div_op1;
          neg_quot_d = bus.div_signed && (bus.div_op1[31] ^ bus.div_op2[31]);
          neg_rem_d  = bus.div_signed && bus.div_op1[31];
          div_zero_d = (bus.div_op2 == 32'd0);
          div_busy_d = 1'b1;
        end else begin
          state_d    = IDLE;
          div_busy_d = 1'b0;
        end
      end
      RUN: begin
        acc_rem_d  = rem_step;
        acc_quot_d = quot_step;
        cnt_d      = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d    = DONE;
          cnt_d      = 5'd0;
          div_quot_d = fin_quot;
          div_rem_d  = fin_rem;
          div_busy_d = 1'b0;
          div_end_d  = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        div_busy_d = 1'b0;
      end
    endcase
  end

  // State register; synchronous reset aborts any divide in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      acc_rem_q  <= 32'd0;
      acc_quot_q <= 32'd0;
      dvsr_q     <= 32'd0;
      dvnd_q     <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      div_quot_q <= 32'd0;
      div_rem_q  <= 32'd0;
      div_busy_q <= 1'b0;
      div_end_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_rem_q  <= acc_rem_d;
      acc_quot_q <= acc_quot_d;
      dvsr_q     <= dvsr_d;
      dvnd_q     <= dvnd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      div_quot_q <= div_quot_d;
      div_rem_q  <= div_rem_d;
      div_busy_q <= div_busy_d;
      div_end_q  <= div_end_d;
    end
  end

  assign bus.div_quot = div_quot_q;
  assign bus.div_rem  = div_rem_q;
  assign bus.div_busy = div_busy_q;
  assign bus.div_end  = div_end_q;

endmodule

// File: tb/tb_divider.sv
// Bench for the iterative divider: a timing/arithmetic reference model
// tracked per cycle, a per-cycle compare process, directed corner cases
// and a randomized sweep.
module tb_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  divider_if dif ();

  divider dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Reference model state: cycle index and start cycle of the latest divide.
  int          cyc       = 0;
  bit          m_active  = 1'b0;
  int          m_start   = 0;
  logic [31:0] m_quot    = 32'd0;
  logic [31:0] m_rem     = 32'd0;
  logic [31:0] exp_quot  = 32'd0;
  logic [31:0] exp_rem   = 32'd0;
  bit          exp_busy  = 1'b0;
  bit          exp_end   = 1'b0;

  // Truncating division with the divide-by-zero convention.
  function automatic void refDivide(input logic [31:0] a, input logic [31:0] b,
                                    input logic sgn,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a divide accepted at the edge opening cycle c is busy for
  // cycles c..c+31 and completes in cycle c+32.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_active = 1'b0;
      exp_quot = 32'd0;
      exp_rem  = 32'd0;
    end else begin
      if (m_active && cyc == m_start + 32) begin
        exp_quot = m_quot;
        exp_rem  = m_rem;
      end
      if (dif.div_begin &&
          !(m_active && (cyc - 1) >= m_start && (cyc - 1) <= m_start + 31)) begin
        m_active = 1'b1;
        m_start  = cyc;
        refDivide(dif.div_op1, dif.div_op2, dif.div_signed, m_quot, m_rem);
      end
    end
    exp_busy = m_active && cyc >= m_start && cyc <= m_start + 31;
    exp_end  = m_active && cyc == m_start + 32;
  end

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_busy", {31'd0, dif.div_busy}, {31'd0, exp_busy});
      checkOutput("cyc_end",  {31'd0, dif.div_end},  {31'd0, exp_end});
      checkOutput("cyc_quot", dif.div_quot, exp_quot);
      checkOutput("cyc_rem",  dif.div_rem,  exp_rem);
    end
  end

  function automatic logic [31:0] pickOperand();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 4)];
      1:       return 32'($urandom_range(1, 1000));
      2:       return 32'(0) - 32'($urandom_range(1, 1000));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge: request a divide at the next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    dif.div_begin  = 1'b1;
    dif.div_op1    = a;
    dif.div_op2    = b;
    dif.div_signed = sgn;
  endtask

  // Follow a started divide to completion and pin latency and results.
  // A begin pulse at cycle pulse_at (0 = none) must be ignored.
  task automatic waitResult(input string name, input logic [31:0] eq,
                            input logic [31:0] er, input int pulse_at);
    int busy_cnt = 0;
    int end_at   = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dif.div_op1    = $urandom;
        dif.div_op2    = $urandom;
        dif.div_signed = 1'($urandom_range(0, 1));
      end
      dif.div_begin = (k == pulse_at);
      if (dif.div_busy) busy_cnt++;
      if (dif.div_end) begin
        end_at = k;
        break;
      end
    end
    dif.div_begin = 1'b0;
    checkOutput({name, "_latency"}, 32'(end_at), 32'd33);
    checkOutput({name, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
    checkOutput({name, "_quot"}, dif.div_quot, eq);
    checkOutput({name, "_rem"}, dif.div_rem, er);
  endtask

  initial begin
    logic [31:0] q;
    logic [31:0] r;
    int          ends;

    dif.div_begin  = 1'b0;
    dif.div_signed = 1'b0;
    dif.div_op1    = 32'd0;
    dif.div_op2    = 32'd0;

    // Pin the reference model itself with hand-computed results.
    refDivide(32'd100, 32'd7, 1'b0, q, r);
    checkOutput("model_100_7_q", q, 32'd14);
    checkOutput("model_100_7_r", r, 32'd2);
    refDivide(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
    checkOutput("model_m7_2_q", q, 32'hFFFF_FFFD);
    checkOutput("model_m7_2_r", r, 32'hFFFF_FFFF);
    refDivide(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
    checkOutput("model_ovf_q", q, 32'h8000_0000);
    checkOutput("model_ovf_r", r, 32'd0);
    refDivide(32'h1234_5678, 32'd0, 1'b1, q, r);
    checkOutput("model_dz_q", q, 32'hFFFF_FFFF);
    checkOutput("model_dz_r", r, 32'h1234_5678);

    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    checkOutput("reset_busy", {31'd0, dif.div_busy}, 32'd0);
    checkOutput("reset_end",  {31'd0, dif.div_end},  32'd0);
    checkOutput("reset_quot", dif.div_quot, 32'd0);
    checkOutput("reset_rem",  dif.div_rem,  32'd0);

    // Basic signed/unsigned cases and special results.
    @(negedge clk);
    applyStimulus(32'd100, 32'd7, 1'b0);
    waitResult("u100_7", 32'd14, 32'd2, 0);
    @(negedge clk);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1);
    waitResult("s_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0);
    waitResult("u_fff9_2", 32'h7FFF_FFFC, 32'd1, 0);
    @(negedge clk);
    applyStimulus(32'h1234_5678, 32'd0, 1'b1);
    waitResult("s_divzero", 32'hFFFF_FFFF, 32'h1234_5678, 0);
    @(negedge clk);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitResult("s_overflow", 32'h8000_0000, 32'd0, 0);

    // Back-to-back: second request issued in the DONE cycle.
    @(negedge clk);
    applyStimulus(32'd1000, 32'd10, 1'b0);
    waitResult("b2b_first", 32'd100, 32'd0, 0);
    applyStimulus(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    waitResult("b2b_second", 32'd1, 32'h7FFF_FFFF, 0);

    // A begin pulse mid-run is ignored and produces no extra completion.
    @(negedge clk);
    applyStimulus(32'd12345, 32'd67, 1'b0);
    waitResult("midrun_begin", 32'd184, 32'd17, 15);
    ends = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.div_end) ends++;
    end
    checkOutput("midrun_no_extra_end", 32'(ends), 32'd0);

    // Reset during RUN aborts the divide and clears the outputs.
    applyStimulus(32'd1000, 32'd3, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      dif.div_begin = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ends = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.div_end) ends++;
    end
    checkOutput("rst_abort_no_end", 32'(ends), 32'd0);
    checkOutput("rst_abort_quot", dif.div_quot, 32'd0);
    checkOutput("rst_abort_rem", dif.div_rem, 32'd0);
    checkOutput("rst_abort_busy", {31'd0, dif.div_busy}, 32'd0);
    applyStimulus(32'd9, 32'd3, 1'b0);
    waitResult("after_rst_9_3", 32'd3, 32'd0, 0);

    // Reset and begin together: the start is dropped.
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'd50, 32'd5, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dif.div_begin = 1'b0;
    checkOutput("rst_begin_busy", {31'd0, dif.div_busy}, 32'd0);
    @(negedge clk);
    checkOutput("rst_begin_busy2", {31'd0, dif.div_busy}, 32'd0);

    // Randomized sweep; the compare process checks every cycle.
    for (int c = 0; c < 60000; c++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 3999) == 0);
      dif.div_begin  = ($urandom_range(0, 2) != 0);
      dif.div_signed = 1'($urandom_range(0, 1));
      dif.div_op1    = pickOperand();
      dif.div_op2    = pickOperand();
    end
    @(negedge clk);
    rst = 1'b0;
    dif.div_begin = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
